// File: rtl/stall_control_param.sv
// Pipeline stall controller with programmable load/jump stall lengths and a
// halt state that waits for an external resume pulse.
module stall_control_param #(
    parameter int unsigned             INS_W    = 24,
    parameter int unsigned             OPC_W    = 5,
    parameter logic [OPC_W-1:0]        LOAD_OPC = 5'b10100,
    parameter logic [OPC_W-1:0]        JUMP_OPC = 5'b11110,
    parameter logic [OPC_W-1:0]        HALT_OPC = 5'b10001,
    parameter int unsigned             LOAD_CYC = 1,
    parameter int unsigned             JUMP_CYC = 2,
    parameter int unsigned             CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INS_W-1:0] ins,
    input  logic             resume,
    output logic             Stall,
    output logic             Stall_pm,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] LOAD_N = CNT_W'(LOAD_CYC);
    localparam logic [CNT_W-1:0] JUMP_N = CNT_W'(JUMP_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StCount, StDone, StHalt} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_stall_pm;
    logic             w_stall;
    logic [OPC_W-1:0] w_opc;
    logic             w_hit_h;
    logic             w_hit_j;
    logic             w_hit_l;
    logic             w_unused_ins;

    // Only the opcode field is decoded; the operand bits pass through untouched.
    assign w_unused_ins = ^ins;

    // Opcode decode; a zero stall length disables that opcode entirely.
    always_comb begin
        w_opc   = ins[INS_W-1 -: OPC_W];
        w_hit_h = (w_opc == HALT_OPC);
        w_hit_j = (w_opc == JUMP_OPC) && (JUMP_CYC != 0);
        w_hit_l = (w_opc == LOAD_OPC) && (LOAD_CYC != 0);
    end

    // Next-state, counter and raw stall; decode only acts in StIdle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (w_hit_h) begin
                    w_stall      = 1'b1;
                    w_state_next = StHalt;
                end else if (w_hit_j) begin
                    w_stall      = 1'b1;
                    w_cnt_next   = JUMP_N - CNT_ONE;
                    w_state_next = (JUMP_CYC >= 2) ? StCount : StDone;
                end else if (w_hit_l) begin
                    w_stall      = 1'b1;
                    w_cnt_next   = LOAD_N - CNT_ONE;
                    w_state_next = (LOAD_CYC >= 2) ? StCount : StDone;
                end
            end
            StCount: begin
                w_stall = 1'b1;
                // Treat 0 like 1 so the counter can never wrap.
                if (r_cnt <= CNT_ONE) begin
                    w_cnt_next   = '0;
                    w_state_next = StDone;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            StDone: begin
                // One unstalled cycle lets the held instruction advance.
                w_cnt_next   = '0;
                w_state_next = StIdle;
            end
            StHalt: begin
                w_stall = 1'b1;
                if (resume) begin
                    w_state_next = StDone;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = StIdle;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Registered copy of Stall for program memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_pm <= 1'b0;
        end else begin
            r_stall_pm <= Stall;
        end
    end

    // Reset masks the combinational stall so nothing leaks out while held.
    assign Stall     = w_stall & ~reset;
    assign Stall_pm  = r_stall_pm;
    assign halted    = (r_state == StHalt);
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_stall_control_param.sv
// Bench for stall_control_param: two instances (default lengths, and
// LOAD_CYC=5 / JUMP_CYC=0) driven by shared stimulus and compared against a
// cycle-level model of stall length, halt and the one-cycle decode mask.
module tb_stall_control_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        resume;
    logic [23:0] ins;

    logic [1:0] w_stall;
    logic [1:0] w_pm;
    logic [1:0] w_halted;
    logic [3:0] w_cnt [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stall_control_param dut_a (
        .clk       (clk),
        .reset     (reset),
        .ins       (ins),
        .resume    (resume),
        .Stall     (w_stall[0]),
        .Stall_pm  (w_pm[0]),
        .halted    (w_halted[0]),
        .stall_cnt (w_cnt[0])
    );

    stall_control_param #(
        .LOAD_CYC (5),
        .JUMP_CYC (0)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .ins       (ins),
        .resume    (resume),
        .Stall     (w_stall[1]),
        .Stall_pm  (w_pm[1]),
        .halted    (w_halted[1]),
        .stall_cnt (w_cnt[1])
    );

    // Model: stall lengths per instance and the observable behaviour state.
    int ld_len [2] = '{1, 5};
    int jp_len [2] = '{2, 0};
    bit m_halt  [2];
    int m_left  [2];   // stall cycles still owed after the current one
    bit m_mask  [2];   // decode masked for one cycle after a sequence ends
    bit m_pm    [2];
    bit m_stall [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // -1 = halt, N>0 = stall length, 0 = no stall for this instance.
    function automatic int req_len(input int k, input logic [23:0] v);
        logic [4:0] opc;
        opc = v[23:19];
        if (opc == 5'b10001) return -1;
        if (opc == 5'b11110 && jp_len[k] != 0) return jp_len[k];
        if (opc == 5'b10100 && ld_len[k] != 0) return ld_len[k];
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_halt[k] = 0;
            m_left[k] = 0;
            m_mask[k] = 0;
            m_pm[k]   = 0;
        end
    endtask

    task automatic check_outputs(input string ph);
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = m_halt[k] || (m_left[k] > 0) || (!m_mask[k] && req_len(k, ins) != 0);
            check_eq($sformatf("%s.stall%0d", ph, k), 32'(w_stall[k]), 32'(m_stall[k]));
            check_eq($sformatf("%s.pm%0d", ph, k), 32'(w_pm[k]), 32'(m_pm[k]));
            check_eq($sformatf("%s.halted%0d", ph, k), 32'(w_halted[k]), 32'(m_halt[k]));
            check_eq($sformatf("%s.cnt%0d", ph, k), 32'(w_cnt[k]), 32'(m_left[k]));
        end
    endtask

    task automatic check_zero(input string ph);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s.stall%0d", ph, k), 32'(w_stall[k]), 32'd0);
            check_eq($sformatf("%s.pm%0d", ph, k), 32'(w_pm[k]), 32'd0);
            check_eq($sformatf("%s.halted%0d", ph, k), 32'(w_halted[k]), 32'd0);
            check_eq($sformatf("%s.cnt%0d", ph, k), 32'(w_cnt[k]), 32'd0);
        end
    endtask

    task automatic model_edge();
        int r;
        for (int k = 0; k < 2; k++) begin
            m_pm[k] = m_stall[k];
            if (m_halt[k]) begin
                if (resume) begin
                    m_halt[k] = 0;
                    m_mask[k] = 1;
                end
            end else if (m_left[k] > 0) begin
                m_left[k]--;
                if (m_left[k] == 0) m_mask[k] = 1;
            end else if (m_mask[k]) begin
                m_mask[k] = 0;
            end else begin
                r = req_len(k, ins);
                if (r < 0) begin
                    m_halt[k] = 1;
                end else if (r > 0) begin
                    m_left[k] = r - 1;
                    if (m_left[k] == 0) m_mask[k] = 1;
                end
            end
        end
    endtask

    // One clock: drive after the falling edge, check, then either clock the
    // model or pulse an asynchronous reset before the rising edge.
    task automatic cycle(input logic [23:0] v, input logic r, input bit do_rst);
        @(negedge clk);
        ins    = v;
        resume = r;
        #1;
        check_outputs("run");
        if (do_rst) begin
            #1 reset = 1'b1;
            #1;
            check_zero("arst");
            model_reset();
            @(posedge clk);
            #1;
            check_zero("rsthold");
            reset = 1'b0;
        end else begin
            @(posedge clk);
            model_edge();
        end
    endtask

    logic [23:0] cur;
    int          sel;

    initial begin
        reset  = 1'b1;
        resume = 1'b0;
        ins    = 24'hF00000;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Jump held through release, then a single jump, then loads.
        cycle(24'hF00000, 1'b0, 1'b0);
        repeat (4) cycle(24'h000000, 1'b0, 1'b0);
        cycle(24'hF00000, 1'b0, 1'b0);
        repeat (8) cycle(24'h000000, 1'b0, 1'b0);
        repeat (6) cycle(24'hA00000, 1'b0, 1'b0);
        repeat (8) cycle(24'h000000, 1'b0, 1'b0);

        // Halt for ten cycles, resume, then resume while idle.
        repeat (10) cycle(24'h880000, 1'b0, 1'b0);
        cycle(24'h880000, 1'b1, 1'b0);
        cycle(24'h000000, 1'b0, 1'b0);
        cycle(24'h000000, 1'b1, 1'b0);
        cycle(24'h000000, 1'b0, 1'b0);

        // Async reset in the third stall cycle of the 5-cycle load.
        cycle(24'hA00000, 1'b0, 1'b0);
        cycle(24'hA00000, 1'b0, 1'b0);
        cycle(24'hA00000, 1'b0, 1'b1);
        repeat (3) cycle(24'h000000, 1'b0, 1'b0);

        // Randomised traffic with held instructions and occasional resets.
        cur = 24'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                sel = $urandom_range(0, 4);
                cur = 24'($urandom);
                case (sel)
                    0: cur[23:19] = 5'b10100;
                    1: cur[23:19] = 5'b11110;
                    2: cur[23:19] = 5'b10001;
                    default: ;
                endcase
            end
            cycle(cur, ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
